// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder: times the gaps between edge pulses, walks the leader/32-bit/stop
// sequence and emits address/command, repeat and error strobes.
module ir_nec_decoder #(
    parameter int CYC_PER_US = 50
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       ir_pos,
    input  logic       ir_neg,
    output logic [7:0] addr_O,
    output logic [7:0] cmd_O,
    output logic       valid_O,
    output logic       rpt_O,
    output logic       err_O
);
    localparam int              PW       = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(CYC_PER_US - 1);
    localparam logic [13:0]     US_SAT   = 14'd16383;

    localparam logic [13:0] LEAD_BURST_MIN = 14'd8000;
    localparam logic [13:0] LEAD_BURST_MAX = 14'd10000;
    localparam logic [13:0] LEAD_SPACE_MIN = 14'd3500;
    localparam logic [13:0] LEAD_SPACE_MAX = 14'd5000;
    localparam logic [13:0] RPT_SPACE_MIN  = 14'd1750;
    localparam logic [13:0] RPT_SPACE_MAX  = 14'd2750;
    localparam logic [13:0] BURST_MIN      = 14'd300;
    localparam logic [13:0] BURST_MAX      = 14'd900;
    localparam logic [13:0] ZERO_MIN       = 14'd300;
    localparam logic [13:0] ZERO_MAX       = 14'd900;
    localparam logic [13:0] ONE_MIN        = 14'd1300;
    localparam logic [13:0] ONE_MAX        = 14'd2000;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LOW,
        LEAD_HIGH,
        RPT_LOW,
        BIT_LOW,
        BIT_HIGH
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [13:0]   us_cnt;
    logic [5:0]    bit_cnt;
    logic [31:0]   sr;

    logic          any_edge;
    logic          both_edges;
    logic [13:0]   t_max;
    logic          burst_ok;
    logic          lead_ok;
    logic          rpt_ok;
    logic          is_zero;
    logic          is_one;
    logic          timeout;
    logic          abort;
    logic          frame_ok;

    function automatic logic in_win(input logic [13:0] d, input logic [13:0] lo,
                                    input logic [13:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    assign any_edge   = ir_pos | ir_neg;
    assign both_edges = ir_pos & ir_neg;
    assign frame_ok   = (sr[15:8] == ~sr[7:0]) && (sr[31:24] == ~sr[23:16]);

    // Microsecond interval timer, restarted by every edge pulse.
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            presc  <= '0;
            us_cnt <= '0;
        end else if (any_edge) begin
            presc  <= '0;
            us_cnt <= '0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
            if (us_cnt != US_SAT) us_cnt <= us_cnt + 14'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        t_max    = US_SAT;
        abort    = 1'b0;
        lead_ok  = in_win(us_cnt, LEAD_SPACE_MIN, LEAD_SPACE_MAX);
        rpt_ok   = in_win(us_cnt, RPT_SPACE_MIN, RPT_SPACE_MAX);
        is_zero  = in_win(us_cnt, ZERO_MIN, ZERO_MAX);
        is_one   = in_win(us_cnt, ONE_MIN, ONE_MAX);
        burst_ok = (state == LEAD_LOW) ? in_win(us_cnt, LEAD_BURST_MIN, LEAD_BURST_MAX)
                                       : in_win(us_cnt, BURST_MIN, BURST_MAX);
        case (state)
            LEAD_LOW:          t_max = LEAD_BURST_MAX;
            LEAD_HIGH:         t_max = LEAD_SPACE_MAX;
            RPT_LOW, BIT_LOW:  t_max = BURST_MAX;
            BIT_HIGH:          t_max = ONE_MAX;
            default:           t_max = US_SAT;
        endcase
        timeout = (state != IDLE) && (us_cnt > t_max);
        // A single edge of the wrong kind is ignored; only the expected edge is judged.
        if (state != IDLE) begin
            if (both_edges || timeout) begin
                abort = 1'b1;
            end else begin
                case (state)
                    LEAD_LOW, RPT_LOW, BIT_LOW: abort = ir_pos && !burst_ok;
                    LEAD_HIGH:                  abort = ir_neg && !lead_ok && !rpt_ok;
                    BIT_HIGH:                   abort = ir_neg && !is_zero && !is_one;
                    default:                    abort = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sr      <= '0;
            addr_O  <= '0;
            cmd_O   <= '0;
            valid_O <= 1'b0;
            rpt_O   <= 1'b0;
            err_O   <= 1'b0;
        end else begin
            valid_O <= 1'b0;
            rpt_O   <= 1'b0;
            err_O   <= 1'b0;
            if (abort) begin
                err_O   <= 1'b1;
                state   <= IDLE;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE:      if (ir_neg && !ir_pos) state <= LEAD_LOW;
                    LEAD_LOW:  if (ir_pos) state <= LEAD_HIGH;
                    LEAD_HIGH: if (ir_neg) begin
                        if (lead_ok) begin
                            state   <= BIT_LOW;
                            bit_cnt <= '0;
                            sr      <= '0;
                        end else begin
                            state <= RPT_LOW;
                        end
                    end
                    RPT_LOW:   if (ir_pos) begin
                        rpt_O <= 1'b1;
                        state <= IDLE;
                    end
                    BIT_LOW:   if (ir_pos) begin
                        if (bit_cnt == 6'd32) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            if (frame_ok) begin
                                addr_O  <= sr[7:0];
                                cmd_O   <= sr[23:16];
                                valid_O <= 1'b1;
                            end else begin
                                err_O <= 1'b1;
                            end
                        end else begin
                            state <= BIT_HIGH;
                        end
                    end
                    BIT_HIGH:  if (ir_neg) begin
                        sr      <= {is_one, sr[31:1]};
                        bit_cnt <= bit_cnt + 6'd1;
                        state   <= BIT_LOW;
                    end
                    default:   state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/ir_nec_decoder.md
# ir_nec_decoder

Decodes NEC infrared remote frames from the one-cycle edge pulses produced by the IR edge-detect stage. The receiver line is idle-high and active-low, so `ir_neg` marks the start of a carrier burst and `ir_pos` marks its end. The block times the intervals between edges with a microsecond counter, runs a frame state machine over the leader, 32 data bits and stop burst, and checks the address and command complements. It emits a registered address/command pair with a valid strobe, a repeat-code strobe, and an error strobe. Its outputs feed the display/control logic downstream.

## Interface
- `CYC_PER_US`, default 50: CLOCK_50 cycles per microsecond tick. The bench may lower it for simulation speed.
- `CLOCK_50` input, 1 bit: the single clock; every register updates on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `ir_pos` input, 1 bit: one-cycle pulse marking the end of a burst (line goes high).
- `ir_neg` input, 1 bit: one-cycle pulse marking the start of a burst (line goes low).
- `addr_O` output, 8 bits: decoded address. Holds its value until the next valid frame.
- `cmd_O` output, 8 bits: decoded command. Holds its value until the next valid frame.
- `valid_O` output, 1 bit: one-cycle strobe; `addr_O`/`cmd_O` were updated this cycle.
- `rpt_O` output, 1 bit: one-cycle strobe; a repeat code was received.
- `err_O` output, 1 bit: one-cycle strobe; the frame was aborted (timing, timeout, or complement failure).

## Operation
- Interval timer:
  - Prescaler counts 0..CYC_PER_US-1.
  - `us_cnt` is 14 bits, increments on prescaler wrap, and saturates at 16383.
  - Both the prescaler and `us_cnt` clear on every accepted edge pulse.
  - "dur" means the `us_cnt` value sampled in the cycle the edge pulse arrives.
- Windows (µs, inclusive):
  - LEAD_BURST 8000-10000
  - LEAD_SPACE 3500-5000
  - RPT_SPACE 1750-2750
  - BURST 300-900
  - ZERO 300-900
  - ONE 1300-2000
- States and transitions:
  - IDLE: on `ir_neg` → LEAD_LOW.
  - LEAD_LOW: on `ir_pos`, dur in LEAD_BURST → LEAD_HIGH; otherwise error.
  - LEAD_HIGH: on `ir_neg`:
    - dur in LEAD_SPACE → BIT_LOW, with bit_cnt=0 and shift register cleared.
    - dur in RPT_SPACE → RPT_LOW.
    - otherwise error.
  - RPT_LOW: on `ir_pos`, dur in BURST → pulse `rpt_O` and go to IDLE; otherwise error.
  - BIT_LOW: on `ir_pos`, dur must be in BURST, otherwise error.
    - If bit_cnt==32, this is the stop burst: run the frame check and go to IDLE.
    - Otherwise → BIT_HIGH.
  - BIT_HIGH: on `ir_neg`:
    - dur in ZERO → shift in 0.
    - dur in ONE → shift in 1.
    - otherwise error.
    - On a good bit: bit_cnt+1 and go to BIT_LOW.
- Shift rule: data arrives LSB first; `sr <= {bit, sr[31:1]}`. After 32 bits:
  - byte0 = sr[7:0] is the address; byte1 = sr[15:8].
  - byte2 = sr[23:16] is the command; byte3 = sr[31:24].
- Frame check:
  - Pass requires byte1 == ~byte0 and byte3 == ~byte2. On pass, load `addr_O`/`cmd_O` and pulse `valid_O`.
  - On fail, pulse `err_O`. `addr_O`/`cmd_O` stay unchanged.
- Timeout: in any non-IDLE state, `us_cnt` above that state's window maximum → error. The maxima are:
  - LEAD_LOW 10000
  - LEAD_HIGH 5000
  - RPT_LOW, BIT_LOW 900
  - BIT_HIGH 2000
- Error action: pulse `err_O` for one cycle, go to IDLE, clear bit_cnt. The triggering edge is consumed, not reused as a new frame start.
- Edges that cannot occur in a state (e.g. `ir_neg` in LEAD_LOW, `ir_pos` in IDLE) are ignored.
- `ir_pos` and `ir_neg` in the same cycle → error, except in IDLE, where both are ignored.

## Timing
- Reset values:
  - `addr_O`=0x00, `cmd_O`=0x00, `valid_O`=0, `rpt_O`=0, `err_O`=0.
  - State IDLE, `us_cnt`=0, prescaler=0, bit_cnt=0, shift register=0.
- Latency: `valid_O`, `rpt_O` and `err_O` assert in the clock cycle after the deciding edge pulse or timeout detection, and last exactly one cycle.
- `valid_O`, `rpt_O` and `err_O` are mutually exclusive in any cycle.
- `addr_O`/`cmd_O` change only in the same cycle that `valid_O` is high.
- `rst` asserted mid-frame: on the next edge the block returns to reset values. No strobe is emitted for the partial frame.
- Counter saturation: at 16383 the counter holds. IDLE never times out.

## Test plan
- Full frame addr 0x04, cmd 0x08 (bytes 04 FB 08 F7):
  - Stimulus: 9000/4500 leader, 560 µs bursts, 560/1690 µs spaces, stop burst.
  - Response: `valid_O` one cycle after the stop `ir_pos`; `addr_O`=0x04, `cmd_O`=0x08; `err_O` never high.
- Repeat code:
  - Stimulus: 9000 low, 2250 high, 560 burst.
  - Response: `rpt_O` one cycle after the final `ir_pos`; `addr_O`/`cmd_O` unchanged.
- Bad complement:
  - Stimulus: frame bytes 04 FA 08 F7.
  - Response: `err_O` one cycle after the stop burst; no `valid_O`; outputs keep their previous values.
- Short leader:
  - Stimulus: 5000 µs low, then a valid frame.
  - Response: `err_O` at the first `ir_pos`, then the following complete frame decodes correctly.
- Timeout and reset:
  - Stimulus: stop edges after bit 10 in BIT_HIGH.
  - Response: `err_O` when `us_cnt` passes 2000.
  - Stimulus: `rst` asserted mid-frame.
  - Response: all outputs 0, and the next full frame decodes correctly.
